// File: rtl/adap_pred_mac_seq.sv
// adap_pred_mac_seq: NZ-tap adaptive zero section plus two-tap pole section.
// The signal estimate is computed serially through one shared multiply-accumulate.
// The zero coefficients adapt by sign-sign update with leakage.
// Optional feature macro: ADAP_PRED_SAT_EN.
//   Defined:   SE and SEZ saturate to the W-bit signed range.
//   Undefined: SE and SEZ keep the low W bits of the accumulator (wrap).
module adap_pred_mac_seq #(
  parameter int NZ = 6,
  parameter int W  = 16,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_trig,
  input  logic                 dly_strb,
  input  logic signed [W-1:0]  DQ,
  input  logic signed [W-1:0]  SR,
  input  logic                 TR,
  input  logic signed [CW-1:0] A1,
  input  logic signed [CW-1:0] A2,
  output logic signed [W-1:0]  SE,
  output logic signed [W-1:0]  SEZ,
  output logic                 DONE,
  output logic                 BUSY
);

  localparam int ACC_W = W + 5;
  localparam int PW    = W + CW;

  // Coefficient range and sign-sign step, held at two extra bits of headroom.
  localparam logic signed [CW+1:0] B_MAX = {3'b000, {(CW-1){1'b1}}};
  localparam logic signed [CW+1:0] B_MIN = {3'b111, {(CW-1){1'b0}}};
  localparam logic signed [CW+1:0] U_POS = (CW+2)'(9'sd128);
  localparam logic signed [CW+1:0] U_NEG = (CW+2)'(-9'sd128);

`ifdef ADAP_PRED_SAT_EN
  localparam logic signed [ACC_W-1:0] O_MAX = {6'b000000, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] O_MIN = {6'b111111, {(W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ZERO = 2'd1,
    S_POLE = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Clamp a widened coefficient back to CW bits.
  function automatic logic signed [CW-1:0] sat_cw(input logic signed [CW+1:0] v);
    logic signed [CW+1:0] r;
    if (v > B_MAX) begin
      r = B_MAX;
    end else if (v < B_MIN) begin
      r = B_MIN;
    end else begin
      r = v;
    end
    return CW'(r);
  endfunction

  // One coefficient step: leak by 1/256, then nudge by +-128 on sign agreement.
  function automatic logic signed [CW-1:0] coef_upd(
    input logic signed [CW-1:0] b,
    input logic                 dq_zero,
    input logic                 dq_sign,
    input logic                 tap_sign
  );
    logic signed [CW+1:0] bx;
    logic signed [CW+1:0] u;
    bx = (CW+2)'(b);
    if (dq_zero) begin
      u = '0;
    end else if (dq_sign == tap_sign) begin
      u = U_POS;
    end else begin
      u = U_NEG;
    end
    return sat_cw(bx - (bx >>> 4'd8) + u);
  endfunction

  // Reduce the accumulator to the output width.
  function automatic logic signed [W-1:0] fmt(input logic signed [ACC_W-1:0] v);
`ifdef ADAP_PRED_SAT_EN
    logic signed [ACC_W-1:0] r;
    if (v > O_MAX) begin
      r = O_MAX;
    end else if (v < O_MIN) begin
      r = O_MIN;
    end else begin
      r = v;
    end
    return W'(r);
`else
    return W'(v);
`endif
  endfunction

  state_t                  state_q, state_d;
  logic [4:0]              idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] snap_q, snap_d;
  logic signed [CW-1:0]    a1_q, a1_d, a2_q, a2_d;
  logic signed [W-1:0]     dq_tap_q [NZ];
  logic signed [W-1:0]     dq_tap_d [NZ];
  logic signed [CW-1:0]    b_q [NZ];
  logic signed [CW-1:0]    b_d [NZ];
  logic signed [W-1:0]     sr1_q, sr1_d, sr2_q, sr2_d;
  logic                    pend_q, pend_d;
  logic signed [W-1:0]     pend_dq_q, pend_dq_d, pend_sr_q, pend_sr_d;
  logic                    pend_tr_q, pend_tr_d;
  logic signed [W-1:0]     se_q, se_d, sez_q, sez_d;
  logic                    done_q, done_d, busy_q, busy_d;

  logic                    last_zero_s;
  logic signed [CW-1:0]    b_sel_s, mul_a_s;
  logic signed [W-1:0]     dqt_sel_s, mul_b_s;
  logic signed [PW-1:0]    prod_s;
  logic signed [ACC_W-1:0] term_s, sum_s;
  logic                    upd_s, upd_tr_s;
  logic signed [W-1:0]     upd_dq_s, upd_sr_s;

  assign last_zero_s = (idx_q == 5'(NZ - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: NZ zero taps, two pole taps, one finish cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_trig) state_d = S_ZERO; else state_d = S_IDLE;
      S_ZERO: if (last_zero_s) state_d = S_POLE; else state_d = S_ZERO;
      S_POLE: if (idx_q[0]) state_d = S_FIN; else state_d = S_POLE;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // MAC operand select and single-cycle product/accumulate term.
  always_comb begin
    b_sel_s   = '0;
    dqt_sel_s = '0;
    for (int i = 0; i < NZ; i++) begin
      b_sel_s   = (idx_q == 5'(i)) ? b_q[i] : b_sel_s;
      dqt_sel_s = (idx_q == 5'(i)) ? dq_tap_q[i] : dqt_sel_s;
    end
    case (state_q)
      S_ZERO: begin
        mul_a_s = b_sel_s;
        mul_b_s = dqt_sel_s;
      end
      S_POLE: begin
        if (idx_q[0]) begin
          mul_a_s = a2_q;
          mul_b_s = sr2_q;
        end else begin
          mul_a_s = a1_q;
          mul_b_s = sr1_q;
        end
      end
      default: begin
        mul_a_s = '0;
        mul_b_s = '0;
      end
    endcase
    prod_s = PW'(mul_a_s) * PW'(mul_b_s);
    term_s = ACC_W'(prod_s >>> (CW - 2));
    sum_s  = acc_q + term_s;
  end

  // FSM outputs and datapath: accumulator, zero snapshot, result registers.
  always_comb begin
    idx_d  = idx_q;
    acc_d  = acc_q;
    snap_d = snap_q;
    a1_d   = a1_q;
    a2_d   = a2_q;
    se_d   = se_q;
    sez_d  = sez_q;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start_trig) begin
          a1_d  = A1;
          a2_d  = A2;
          acc_d = '0;
          idx_d = 5'd0;
        end else begin
          idx_d = 5'd0;
        end
      end
      S_ZERO: begin
        acc_d = sum_s;
        if (last_zero_s) begin
          snap_d = sum_s;
          idx_d  = 5'd0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_POLE: begin
        acc_d = sum_s;
        if (idx_q[0]) begin
          se_d   = fmt(sum_s);
          sez_d  = fmt(snap_q);
          done_d = 1'b1;
          idx_d  = 5'd0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_FIN: idx_d = 5'd0;
      default: idx_d = 5'd0;
    endcase
  end

  // Sample update: immediate in IDLE, deferred to FIN while a computation runs.
  always_comb begin
    if (dly_strb) begin
      upd_dq_s = DQ;
      upd_sr_s = SR;
      upd_tr_s = TR;
    end else begin
      upd_dq_s = pend_dq_q;
      upd_sr_s = pend_sr_q;
      upd_tr_s = pend_tr_q;
    end
    pend_dq_d = pend_dq_q;
    pend_sr_d = pend_sr_q;
    pend_tr_d = pend_tr_q;
    case (state_q)
      S_IDLE: begin
        upd_s  = dly_strb;
        pend_d = 1'b0;
      end
      S_ZERO, S_POLE: begin
        upd_s  = 1'b0;
        pend_d = pend_q | dly_strb;
        if (dly_strb) begin
          pend_dq_d = DQ;
          pend_sr_d = SR;
          pend_tr_d = TR;
        end else begin
          pend_tr_d = pend_tr_q;
        end
      end
      S_FIN: begin
        upd_s  = dly_strb | pend_q;
        pend_d = 1'b0;
      end
      default: begin
        upd_s  = 1'b0;
        pend_d = 1'b0;
      end
    endcase
    sr1_d = sr1_q;
    sr2_d = sr2_q;
    for (int i = 0; i < NZ; i++) begin
      b_d[i]      = b_q[i];
      dq_tap_d[i] = dq_tap_q[i];
    end
    if (upd_s) begin
      for (int i = 0; i < NZ; i++) begin
        if (upd_tr_s) begin
          b_d[i] = '0;
        end else begin
          b_d[i] = coef_upd(b_q[i], (upd_dq_s == '0), upd_dq_s[W-1], dq_tap_q[i][W-1]);
        end
      end
      dq_tap_d[0] = upd_dq_s;
      for (int i = 1; i < NZ; i++) begin
        dq_tap_d[i] = dq_tap_q[i-1];
      end
      sr1_d = upd_sr_s;
      sr2_d = sr1_q;
    end else begin
      sr1_d = sr1_q;
    end
  end

  // Datapath, tap, coefficient and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q     <= 5'd0;
      acc_q     <= '0;
      snap_q    <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      pend_q    <= 1'b0;
      pend_dq_q <= '0;
      pend_sr_q <= '0;
      pend_tr_q <= 1'b0;
      se_q      <= '0;
      sez_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NZ; i++) begin
        b_q[i]      <= '0;
        dq_tap_q[i] <= '0;
      end
    end else begin
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      snap_q    <= snap_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      sr1_q     <= sr1_d;
      sr2_q     <= sr2_d;
      pend_q    <= pend_d;
      pend_dq_q <= pend_dq_d;
      pend_sr_q <= pend_sr_d;
      pend_tr_q <= pend_tr_d;
      se_q      <= se_d;
      sez_q     <= sez_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      for (int i = 0; i < NZ; i++) begin
        b_q[i]      <= b_d[i];
        dq_tap_q[i] <= dq_tap_d[i];
      end
    end
  end

  assign SE   = se_q;
  assign SEZ  = sez_q;
  assign DONE = done_q;
  assign BUSY = busy_q;

endmodule
